// File: rtl/uart_rx_fsm_top.sv
// UART receiver: oversampled start/data/parity/stop recovery with 3-sample
// majority voting, delivering one-cycle Data_Valid / Par_Err / Stp_Err pulses.
module uart_rx_fsm_top #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BCW = $clog2(DATA_WIDTH + 4);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state;
  logic [5:0]              edge_cnt;
  logic [5:0]              p_lat;
  logic [BCW-1:0]          bit_cnt;
  logic                    par_en_lat;
  logic                    par_typ_lat;
  logic                    par_err_hold;
  logic [2:0]              smp;
  logic [DATA_WIDTH-1:0]   shift_reg;

  logic [5:0] half;
  logic [5:0] smp_a;
  logic [5:0] smp_b;
  logic [5:0] smp_c;
  logic [5:0] chk_edge;
  logic [5:0] last_edge;
  logic       is_last;
  logic       bit_val;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign half      = p_lat >> 1;
  assign smp_a     = half - 6'd1;
  assign smp_b     = half;
  assign smp_c     = half + 6'd1;
  assign chk_edge  = half + 6'd2;
  assign last_edge = p_lat - 6'd1;
  assign is_last   = (edge_cnt == last_edge);
  assign bit_val   = maj3(smp);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      p_lat        <= '0;
      par_en_lat   <= 1'b0;
      par_typ_lat  <= 1'b0;
      par_err_hold <= 1'b0;
      smp          <= '0;
      shift_reg    <= '0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Par_Err      <= 1'b0;
      Stp_Err      <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= is_last ? 6'd0 : edge_cnt + 6'd1;
        if (is_last) bit_cnt <= bit_cnt + BCW'(1);
        if (edge_cnt == smp_a) smp[0] <= RX_IN;
        if (edge_cnt == smp_b) smp[1] <= RX_IN;
        if (edge_cnt == smp_c) smp[2] <= RX_IN;
      end

      case (state)
        IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          // The detecting cycle counts as edge 0 of the start bit.
          if (!RX_IN) begin
            state        <= START;
            edge_cnt     <= 6'd1;
            p_lat        <= Prescale;
            par_en_lat   <= PAR_EN;
            par_typ_lat  <= PAR_TYP;
            par_err_hold <= 1'b0;
          end
        end
        START: begin
          if (edge_cnt == chk_edge && bit_val) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
          end else if (is_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (is_last) begin
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == BCW'(DATA_WIDTH))
              state <= par_en_lat ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (is_last) begin
            par_err_hold <= ((^shift_reg) ^ bit_val) != par_typ_lat;
            state        <= STOP;
          end
        end
        STOP: begin
          // Pulses land in the first IDLE cycle after the stop bit.
          if (is_last) begin
            state   <= IDLE;
            Stp_Err <= ~bit_val;
            Par_Err <= par_err_hold;
            if (bit_val && !par_err_hold) begin
              Data_Valid <= 1'b1;
              P_DATA     <= shift_reg;
            end
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm_top.sv
// Bench for uart_rx_fsm_top: frames driven bit by bit, expected pulses queued
// at frame start and matched against observed pulses by cycle number.
module tb_uart_rx_fsm_top;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] pre;
  logic       par_en;
  logic       par_typ;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  typedef struct {
    int         c;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_fsm_top #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (pre),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST === 1'b0 && (Data_Valid || Par_Err || Stp_Err)) begin
        total = total + 1;
        if (sb.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_pulse cyc=%0d dv=%b pe=%b se=%b data=%h",
                   cyc, Data_Valid, Par_Err, Stp_Err, P_DATA);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.c || Data_Valid !== e.dv || Par_Err !== e.pe ||
              Stp_Err !== e.se || P_DATA !== e.d) begin
            bad = bad + 1;
            $display("FAIL pulse got cyc=%0d dv=%b pe=%b se=%b data=%h want cyc=%0d dv=%b pe=%b se=%b data=%h",
                     cyc, Data_Valid, Par_Err, Stp_Err, P_DATA, e.c, e.dv, e.pe, e.se, e.d);
          end
        end
      end
    end
  end

  task automatic drive_frame(input logic [7:0] d, input bit pbit, input bit stop);
    exp_t e;
    int   p;
    int   n;
    bit   perr;
    bit   serr;
    p    = int'(pre);
    perr = par_en && (((^d) ^ pbit) != par_typ);
    serr = !stop;
    n    = par_en ? 11 : 10;
    e.c  = cyc + n * p;
    e.dv = !perr && !serr;
    e.pe = perr;
    e.se = serr;
    e.d  = e.dv ? d : last_good;
    if (e.dv) last_good = d;
    sb.push_back(e);
    RX_IN = 1'b0;
    repeat (p) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(negedge CLK);
    end
    if (par_en) begin
      RX_IN = pbit;
      repeat (p) @(negedge CLK);
    end
    RX_IN = stop;
    repeat (p) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge CLK);
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    #1;
    total = total + 1;
    if (P_DATA !== 8'h00 || Data_Valid !== 1'b0 || Par_Err !== 1'b0 || Stp_Err !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_outputs got data=%h dv=%b pe=%b se=%b want all 0",
               P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
  endtask

  task automatic test_no_parity();
    pre = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    @(negedge CLK);
    drive_frame(8'hA5, 1'b0, 1'b1);
    wait_drain();
    total = total + 1;
    if (sb.size() != 0 || P_DATA !== 8'hA5) begin
      bad = bad + 1;
      $display("FAIL no_parity pending=%0d data=%h want pending=0 data=a5", sb.size(), P_DATA);
      sb.delete();
    end
  endtask

  task automatic test_parity();
    pre = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    @(negedge CLK);
    drive_frame(8'h3C, 1'b0, 1'b1);
    drive_frame(8'h3C, 1'b1, 1'b1);
    wait_drain();
    total = total + 1;
    if (sb.size() != 0 || P_DATA !== 8'h3C) begin
      bad = bad + 1;
      $display("FAIL parity_even pending=%0d data=%h want pending=0 data=3c", sb.size(), P_DATA);
      sb.delete();
    end
    par_typ = 1'b1;
    drive_frame(8'h96, 1'b1, 1'b1);
    drive_frame(8'h3C, 1'b0, 1'b0);
    wait_drain();
    total = total + 1;
    if (sb.size() != 0 || P_DATA !== 8'h96) begin
      bad = bad + 1;
      $display("FAIL parity_odd pending=%0d data=%h want pending=0 data=96", sb.size(), P_DATA);
      sb.delete();
    end
  endtask

  task automatic test_stop_err();
    pre = 6'd32; par_en = 1'b0; par_typ = 1'b0;
    @(negedge CLK);
    drive_frame(8'h55, 1'b0, 1'b0);
    wait_drain();
    total = total + 1;
    if (sb.size() != 0 || P_DATA !== last_good) begin
      bad = bad + 1;
      $display("FAIL stop_err pending=%0d data=%h want pending=0 data=%h", sb.size(), P_DATA, last_good);
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    pre = 6'd16; par_en = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    drive_frame(8'h81, 1'b0, 1'b1);
    wait_drain();
    total = total + 1;
    if (sb.size() != 0 || P_DATA !== 8'h81) begin
      bad = bad + 1;
      $display("FAIL glitch pending=%0d data=%h want pending=0 data=81", sb.size(), P_DATA);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    pre = 6'd16; par_en = 1'b0;
    @(negedge CLK);
    drive_frame(8'h12, 1'b0, 1'b1);
    drive_frame(8'h34, 1'b0, 1'b1);
    wait_drain();
    total = total + 1;
    if (sb.size() != 0 || P_DATA !== 8'h34) begin
      bad = bad + 1;
      $display("FAIL back_to_back pending=%0d data=%h want pending=0 data=34", sb.size(), P_DATA);
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    pre = 6'd16; par_en = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b0;
    repeat (16) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (54) @(negedge CLK);
    RST = 1'b1;
    last_good = 8'h00;
    #1;
    total = total + 1;
    if (P_DATA !== 8'h00 || Data_Valid || Par_Err || Stp_Err) begin
      bad = bad + 1;
      $display("FAIL mid_reset_outputs got data=%h dv=%b pe=%b se=%b want all 0",
               P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    repeat (10) @(negedge CLK);
    RST = 1'b0;
    repeat (300) @(negedge CLK);
    total = total + 1;
    if (P_DATA !== 8'h00 || Data_Valid || Par_Err || Stp_Err) begin
      bad = bad + 1;
      $display("FAIL post_reset_idle got data=%h dv=%b pe=%b se=%b want all 0",
               P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    drive_frame(8'h0F, 1'b0, 1'b1);
    wait_drain();
    total = total + 1;
    if (sb.size() != 0 || P_DATA !== 8'h0F) begin
      bad = bad + 1;
      $display("FAIL after_reset_frame pending=%0d data=%h want pending=0 data=0f", sb.size(), P_DATA);
      sb.delete();
    end
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; pre = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    test_no_parity();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
